// File: rtl/wavetable_xfade_mv_pkg.sv
// Shared widths, mirror-mode encodings and mode decoding for the wavetable
// crossfade generator.
package wavetable_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PHASE_W  = 7;
  localparam int WFM_W    = 8;
  localparam int FACTOR_W = 8;
  localparam int VOICES   = 4;
  localparam int VID_W    = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [1:0] {
    MIR_ODD    = 2'd0,
    MIR_EVEN   = 2'd1,
    MIR_REPEAT = 2'd2
  } mirror_e;

  // The unused encoding 3 behaves as odd symmetry.
  function automatic mirror_e decode_mirror(input logic [1:0] mode);
    return (mode == 2'd3) ? MIR_ODD : mirror_e'(mode);
  endfunction

endpackage

// File: rtl/wavetable_xfade_mv_if.sv
// Beat-in / sample-out bundle between the NCO, the generator and the mixer.
interface wavetable_xfade_mv_if #(
  parameter int SAMPLE_W = wavetable_pkg::SAMPLE_W,
  parameter int PHASE_W  = wavetable_pkg::PHASE_W,
  parameter int WFM_W    = wavetable_pkg::WFM_W,
  parameter int FACTOR_W = wavetable_pkg::FACTOR_W,
  parameter int VOICES   = wavetable_pkg::VOICES
);
  import wavetable_pkg::*;

  localparam int VID_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic                phase_dv;
  logic [PHASE_W-1:0]  phase;
  logic [VID_W-1:0]    voice_in;
  logic [WFM_W-1:0]    wfm_num_l;
  logic [WFM_W-1:0]    wfm_num_r;
  logic [FACTOR_W-1:0] factor;
  logic [1:0]          mirror_mode;

  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_dv;
  logic [VID_W-1:0]    voice_out;
  logic                frame_dv;

  modport master (
    output phase_dv, phase, voice_in, wfm_num_l, wfm_num_r, factor, mirror_mode,
    input  sample_out, sample_out_dv, voice_out, frame_dv
  );

  modport slave (
    input  phase_dv, phase, voice_in, wfm_num_l, wfm_num_r, factor, mirror_mode,
    output sample_out, sample_out_dv, voice_out, frame_dv
  );

endinterface

// File: rtl/wavetable_rom_dp.sv
// Dual-port synchronous wavetable ROM, one half-period per waveform.
// Table 0 is a ramp (4*i), table 1 a constant 200, all others silent.
module wavetable_rom_dp #(
  parameter int SAMPLE_W = wavetable_pkg::SAMPLE_W,
  parameter int PHASE_W  = wavetable_pkg::PHASE_W,
  parameter int WFM_W    = wavetable_pkg::WFM_W
) (
  input  logic                clk,
  input  logic                re_a,
  input  logic [PHASE_W-2:0]  addr_sample_a,
  input  logic [WFM_W-1:0]    addr_wfm_a,
  output logic [SAMPLE_W-1:0] data_a,
  input  logic                re_b,
  input  logic [PHASE_W-2:0]  addr_sample_b,
  input  logic [WFM_W-1:0]    addr_wfm_b,
  output logic [SAMPLE_W-1:0] data_b
);

  function automatic logic [SAMPLE_W-1:0] table_word(input logic [WFM_W-1:0]   wfm,
                                                     input logic [PHASE_W-2:0] idx);
    logic [SAMPLE_W-1:0] word;
    word = '0;
    if (wfm == WFM_W'(0)) begin
      word = SAMPLE_W'({idx, 2'b00});
    end else if (wfm == WFM_W'(1)) begin
      word = SAMPLE_W'(200);
    end
    return word;
  endfunction

  always_ff @(posedge clk) begin
    if (re_a) data_a <= table_word(addr_wfm_a, addr_sample_a);
    if (re_b) data_b <= table_word(addr_wfm_b, addr_sample_b);
  end

endmodule

// File: rtl/wavetable_xfade_mv.sv
// Three-stage voice-tagged wavetable generator: table read with symmetry
// folding, per-side weighting, then sum-and-scale to the output sample.
module wavetable_xfade_mv #(
  parameter int SAMPLE_W = wavetable_pkg::SAMPLE_W,
  parameter int PHASE_W  = wavetable_pkg::PHASE_W,
  parameter int WFM_W    = wavetable_pkg::WFM_W,
  parameter int FACTOR_W = wavetable_pkg::FACTOR_W,
  parameter int VOICES   = wavetable_pkg::VOICES
) (
  input logic                  clk,
  input logic                  rst_n,
  wavetable_xfade_mv_if.slave  bus
);
  import wavetable_pkg::*;

  localparam int VID_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int IDX_W = PHASE_W - 1;
  localparam int PL_W  = FACTOR_W + SAMPLE_W + 1;
  localparam int PR_W  = FACTOR_W + SAMPLE_W;

  mirror_e             mode_in;
  logic                half_in;
  logic [IDX_W-1:0]    idx_in;
  logic [IDX_W-1:0]    rom_addr;
  logic [SAMPLE_W-1:0] rom_l, rom_r;

  // Odd and even symmetry read the second half-period backwards.
  always_comb begin
    mode_in  = decode_mirror(bus.mirror_mode);
    half_in  = bus.phase[PHASE_W-1];
    idx_in   = bus.phase[IDX_W-1:0];
    rom_addr = (half_in && mode_in != MIR_REPEAT) ? ~idx_in : idx_in;
  end

  wavetable_rom_dp #(
    .SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W), .WFM_W(WFM_W)
  ) u_rom (
    .clk          (clk),
    .re_a         (bus.phase_dv),
    .addr_sample_a(rom_addr),
    .addr_wfm_a   (bus.wfm_num_l),
    .data_a       (rom_l),
    .re_b         (bus.phase_dv),
    .addr_sample_b(rom_addr),
    .addr_wfm_b   (bus.wfm_num_r),
    .data_b       (rom_r)
  );

  logic                s1_valid, s1_half;
  mirror_e             s1_mode;
  logic [FACTOR_W-1:0] s1_factor;
  logic [VID_W-1:0]    s1_voice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_half   <= 1'b0;
      s1_mode   <= MIR_ODD;
      s1_factor <= '0;
      s1_voice  <= '0;
    end else begin
      s1_valid <= bus.phase_dv;
      if (bus.phase_dv) begin
        s1_half   <= half_in;
        s1_mode   <= mode_in;
        s1_factor <= bus.factor;
        s1_voice  <= bus.voice_in;
      end
    end
  end

  logic                invert;
  logic [SAMPLE_W-1:0] sl, sr;
  logic [FACTOR_W:0]   wl;
  logic [PL_W-1:0]     pl_next;
  logic [PR_W-1:0]     pr_next;

  // Odd symmetry flips the second half about full scale; ~x == max - x.
  always_comb begin
    invert  = s1_half && (s1_mode == MIR_ODD);
    sl      = invert ? ~rom_l : rom_l;
    sr      = invert ? ~rom_r : rom_r;
    wl      = {1'b1, {FACTOR_W{1'b0}}} - {1'b0, s1_factor};
    pl_next = PL_W'(wl) * PL_W'(sl);
    pr_next = PR_W'(s1_factor) * PR_W'(sr);
  end

  logic             s2_valid;
  logic [PL_W-1:0]  s2_pl;
  logic [PR_W-1:0]  s2_pr;
  logic [VID_W-1:0] s2_voice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pl    <= '0;
      s2_pr    <= '0;
      s2_voice <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pl    <= pl_next;
        s2_pr    <= pr_next;
        s2_voice <= s1_voice;
      end
    end
  end

  logic [PL_W-1:0] sum;
  assign sum = s2_pl + PL_W'(s2_pr);

  // The weights always total 2^FACTOR_W, so the scaled sum fits without clipping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sample_out    <= '0;
      bus.sample_out_dv <= 1'b0;
      bus.voice_out     <= '0;
      bus.frame_dv      <= 1'b0;
    end else begin
      bus.sample_out_dv <= s2_valid;
      bus.frame_dv      <= s2_valid && (s2_voice == VID_W'(VOICES - 1));
      if (s2_valid) begin
        bus.sample_out <= SAMPLE_W'(sum >> FACTOR_W);
        bus.voice_out  <= s2_voice;
      end
    end
  end

endmodule

// File: tb/tb_wavetable_xfade_mv.sv
// Bench for wavetable_xfade_mv: directed vector table, reset and control
// sequences, plus randomized beats scored against an arithmetic model.
module tb_wavetable_xfade_mv;
  import wavetable_pkg::*;

  localparam int HALF_N = 1 << (PHASE_W - 1);
  localparam int S_MAX  = (1 << SAMPLE_W) - 1;
  localparam int F_ONE  = 1 << FACTOR_W;

  typedef struct {
    int ph; int wl; int wr; int f; int m; int v; int exp_s; int exp_frame;
  } vec_t;

  typedef struct { int due; int s; int v; } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests_run;
  int   tests_failed;
  bit   mon_en;
  exp_t sb[$];
  vec_t vecs[9];

  wavetable_xfade_mv_if bus ();

  wavetable_xfade_mv dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_table(int wfm, int idx);
    if (wfm == 0) return 4 * idx;
    if (wfm == 1) return 200;
    return 0;
  endfunction

  // Reference: fold phase into the half-period, read, mirror, weighted average.
  function automatic int model_sample(int ph, int wl, int wr, int f, int m);
    int half, idx, mm, sl, sr;
    half = ph / HALF_N;
    idx  = ph % HALF_N;
    mm   = (m == 3) ? 0 : m;
    if (half == 1 && mm != 2) idx = HALF_N - 1 - idx;
    sl = ref_table(wl, idx);
    sr = ref_table(wr, idx);
    if (half == 1 && mm == 0) begin
      sl = S_MAX - sl;
      sr = S_MAX - sr;
    end
    return ((F_ONE - f) * sl + f * sr) / F_ONE;
  endfunction

  task automatic checkValue(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.phase       = PHASE_W'(v.ph);
    bus.wfm_num_l   = WFM_W'(v.wl);
    bus.wfm_num_r   = WFM_W'(v.wr);
    bus.factor      = FACTOR_W'(v.f);
    bus.mirror_mode = 2'(v.m);
    bus.voice_in    = VID_W'(v.v);
    bus.phase_dv    = 1'b1;
    if (mon_en) sb.push_back('{cyc + 3, model_sample(v.ph, v.wl, v.wr, v.f, v.m), v.v});
  endtask

  // Expects the beat driven two negedges earlier to surface on the middle one.
  task automatic checkOutput(input string name, input vec_t v);
    @(negedge clk);
    checkValue({name, "_early_dv"}, int'(bus.sample_out_dv), 0);
    @(negedge clk);
    checkValue({name, "_dv"}, int'(bus.sample_out_dv), 1);
    checkValue({name, "_sample"}, int'(bus.sample_out), v.exp_s);
    checkValue({name, "_voice"}, int'(bus.voice_out), v.v);
    checkValue({name, "_frame"}, int'(bus.frame_dv), v.exp_frame);
    @(negedge clk);
    checkValue({name, "_late_dv"}, int'(bus.sample_out_dv), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        checkValue("mon_dv", int'(bus.sample_out_dv), 1);
        checkValue("mon_sample", int'(bus.sample_out), e.s);
        checkValue("mon_voice", int'(bus.voice_out), e.v);
        checkValue("mon_frame", int'(bus.frame_dv), (e.v == VOICES - 1) ? 1 : 0);
      end else begin
        checkValue("mon_idle_dv", int'(bus.sample_out_dv), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    int   last;
    tests_run = 0;
    tests_failed = 0;
    mon_en = 1'b0;
    cyc = 0;

    vecs[0] = '{5,   0, 0, 0,   0, 2, 20,  0};
    vecs[1] = '{69,  0, 0, 0,   0, 0, 23,  0};
    vecs[2] = '{69,  0, 0, 0,   1, 1, 232, 0};
    vecs[3] = '{69,  0, 0, 0,   2, 3, 20,  1};
    vecs[4] = '{69,  0, 0, 0,   3, 0, 23,  0};
    vecs[5] = '{10,  0, 1, 128, 0, 1, 120, 0};
    vecs[6] = '{63,  0, 1, 255, 0, 3, 200, 1};
    vecs[7] = '{100, 1, 0, 64,  1, 2, 177, 0};
    vecs[8] = '{100, 1, 0, 64,  0, 2, 78,  0};

    rst_n = 1'b0;
    bus.phase_dv = 1'b0;
    bus.phase = '0;
    bus.voice_in = '0;
    bus.wfm_num_l = '0;
    bus.wfm_num_r = '0;
    bus.factor = '0;
    bus.mirror_mode = '0;

    repeat (3) @(negedge clk);
    checkValue("rst_dv", int'(bus.sample_out_dv), 0);
    checkValue("rst_sample", int'(bus.sample_out), 0);
    checkValue("rst_voice", int'(bus.voice_out), 0);
    checkValue("rst_frame", int'(bus.frame_dv), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      bus.phase_dv = 1'b0;
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back voices 0..3, then randomized traffic, both scoreboarded.
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = '{4 + 4 * i + ((i == 3) ? 64 : 0), 0, 0, 0, 0, i, 0, 0};
      applyStimulus(v);
      @(negedge clk);
    end
    bus.phase_dv = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0) begin
        v.ph = int'($urandom_range(2 * HALF_N - 1));
        v.wl = int'($urandom_range(3));
        v.wr = int'($urandom_range(3));
        v.f  = int'($urandom_range(F_ONE - 1));
        v.m  = int'($urandom_range(3));
        v.v  = int'($urandom_range(VOICES - 1));
        applyStimulus(v);
      end else begin
        bus.phase_dv = 1'b0;
        bus.factor = FACTOR_W'($urandom);
      end
      @(negedge clk);
    end
    bus.phase_dv = 1'b0;
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    checkValue("drain_pending", sb.size(), 0);
    mon_en = 1'b0;
    @(negedge clk);

    // Reset with two beats in flight: they must never emerge.
    applyStimulus(vecs[2]);
    @(negedge clk);
    bus.phase_dv = 1'b0;
    checkOutput("pre_reset", vecs[2]);
    applyStimulus(vecs[0]);
    @(negedge clk);
    applyStimulus(vecs[5]);
    @(negedge clk);
    bus.phase_dv = 1'b0;
    rst_n = 1'b0;
    #1;
    checkValue("midrst_dv", int'(bus.sample_out_dv), 0);
    checkValue("midrst_sample", int'(bus.sample_out), 0);
    checkValue("midrst_voice", int'(bus.voice_out), 0);
    checkValue("midrst_frame", int'(bus.frame_dv), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkValue("post_rst_dv", int'(bus.sample_out_dv), 0);
    end
    applyStimulus(vecs[7]);
    @(negedge clk);
    bus.phase_dv = 1'b0;
    checkOutput("after_rst", vecs[7]);

    // Control churn without phase_dv must leave the output untouched.
    last = vecs[7].exp_s;
    for (int i = 0; i < 5; i++) begin
      bus.factor = FACTOR_W'($urandom);
      bus.mirror_mode = 2'($urandom);
      bus.wfm_num_l = WFM_W'($urandom_range(1));
      bus.wfm_num_r = WFM_W'($urandom_range(1));
      bus.phase = PHASE_W'($urandom);
      @(negedge clk);
      checkValue("idle_dv", int'(bus.sample_out_dv), 0);
      checkValue("idle_sample", int'(bus.sample_out), last);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
